// File: rtl/temperature_alarm_monitor_if.sv
// rtl/temperature_alarm_monitor_if.sv - sample/alarm bus between temperature source, monitor and alert stage
interface temperature_alarm_monitor_if;
    logic       sampleValid;
    logic [7:0] temperature;
    logic       alarmAck;
    logic [7:0] avgTemp;
    logic       avgValid;
    logic [1:0] tempState;
    logic       alarm;

    modport master (
        output sampleValid, temperature, alarmAck,
        input  avgTemp, avgValid, tempState, alarm
    );

    modport slave (
        input  sampleValid, temperature, alarmAck,
        output avgTemp, avgValid, tempState, alarm
    );
endinterface

// File: rtl/temperature_alarm_monitor.sv
// rtl/temperature_alarm_monitor.sv - moving-average temperature classifier with persistence, hysteresis and sticky alarm
module temperature_alarm_monitor #(
    parameter int         AVG_LOG2 = 2,
    parameter logic [7:0] HIGH_TH  = 8'd38,
    parameter logic [7:0] LOW_TH   = 8'd35,
    parameter logic [7:0] HYST     = 8'd1,
    parameter int         PERSIST  = 3
) (
    input  logic clk,
    input  logic rst,
    temperature_alarm_monitor_if.slave bus
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam int CW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_HIGH   = 2'b01,
        ST_LOW    = 2'b10
    } state_t;

    logic [7:0]    win_q [N];
    logic [7:0]    win_d [N];
    logic [SW-1:0] sum_q, sum_d, sum_next;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_run;
    logic          dir_high_q, dir_high_d;
    state_t        state_q, state_d;
    logic [7:0]    avg_q, avg_d, avg_next;
    logic          avg_valid_q, avg_valid_d;
    logic          alarm_q, alarm_d, alarm_set;
    logic          qual_h, qual_l, exit_h, exit_l;

    // Modular arithmetic: a transient wrap of sum+temperature is undone by subtracting the oldest sample.
    assign sum_next = sum_q + SW'(bus.temperature) - SW'(win_q[N-1]);
    assign avg_next = sum_next[SW-1:AVG_LOG2];
    assign qual_h   = avg_next >= HIGH_TH;
    assign qual_l   = avg_next <= LOW_TH;
    assign exit_h   = avg_next < (HIGH_TH - HYST);
    assign exit_l   = {1'b0, avg_next} > ({1'b0, LOW_TH} + {1'b0, HYST});

    always_comb begin
        win_d       = win_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        cnt_run     = cnt_q;
        dir_high_d  = dir_high_q;
        state_d     = state_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        alarm_set   = 1'b0;

        if (bus.sampleValid) begin
            win_d[0] = bus.temperature;
            for (int i = 1; i < N; i++) begin
                win_d[i] = win_q[i-1];
            end
            sum_d = sum_next;
            if (fill_q != FW'(N)) begin
                fill_d = fill_q + FW'(1);
            end

            if (fill_q >= FW'(N - 1)) begin
                avg_valid_d = 1'b1;
                avg_d       = avg_next;
                unique case (state_q)
                    ST_NORMAL: begin
                        if (qual_h || qual_l) begin
                            if (cnt_q != '0 && dir_high_q == qual_h) begin
                                cnt_run = (cnt_q == CW'(PERSIST)) ? cnt_q : cnt_q + CW'(1);
                            end else begin
                                cnt_run = CW'(1);
                            end
                            dir_high_d = qual_h;
                            if (cnt_run == CW'(PERSIST)) begin
                                state_d   = qual_h ? ST_HIGH : ST_LOW;
                                cnt_d     = '0;
                                alarm_set = 1'b1;
                            end else begin
                                cnt_d = cnt_run;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    ST_HIGH: begin
                        if (exit_h) begin
                            state_d = ST_NORMAL;
                            cnt_d   = '0;
                        end
                    end
                    ST_LOW: begin
                        if (exit_l) begin
                            state_d = ST_NORMAL;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_NORMAL;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Acknowledge is honoured only once the temperature is back to NORMAL; a fresh entry overrides it.
        alarm_d = alarm_q;
        if (alarm_set) begin
            alarm_d = 1'b1;
        end else if (bus.alarmAck && state_q == ST_NORMAL) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            dir_high_q  <= 1'b0;
            state_q     <= ST_NORMAL;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            dir_high_q  <= dir_high_d;
            state_q     <= state_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.avgTemp   = avg_q;
    assign bus.avgValid  = avg_valid_q;
    assign bus.tempState = state_q;
    assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_temperature_alarm_monitor.sv
// tb/tb_temperature_alarm_monitor.sv - directed and randomized checks of temperature_alarm_monitor against a reference model
module tb_temperature_alarm_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    temperature_alarm_monitor_if bus ();

    temperature_alarm_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: last four accepted samples and the classification rules in plain arithmetic.
    int q[$];
    int m_state    = 0;
    int m_run      = 0;
    int m_run_dir  = 0;
    int m_alarm    = 0;
    int m_avg      = 0;
    int m_avgvalid = 0;

    task automatic model_step(input logic r, input logic v, input int t, input logic a);
        int prev_state;
        int sum;
        int dir;
        bit entering;
        if (r) begin
            q.delete();
            m_state = 0; m_run = 0; m_run_dir = 0;
            m_alarm = 0; m_avg = 0; m_avgvalid = 0;
            return;
        end
        prev_state = m_state;
        entering   = 0;
        m_avgvalid = 0;
        if (v) begin
            q.push_back(t);
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                m_avg = sum / 4;
                m_avgvalid = 1;
                if (m_state == 0) begin
                    dir = (m_avg >= 38) ? 1 : (m_avg <= 35) ? 2 : 0;
                    if (dir == 0) begin
                        m_run = 0;
                    end else begin
                        m_run = (m_run > 0 && m_run_dir == dir) ? m_run + 1 : 1;
                        m_run_dir = dir;
                        if (m_run >= 3) begin
                            m_state = dir;
                            m_run = 0;
                            entering = 1;
                        end
                    end
                end else if (m_state == 1 && m_avg < 37) begin
                    m_state = 0; m_run = 0;
                end else if (m_state == 2 && m_avg > 36) begin
                    m_state = 0; m_run = 0;
                end
            end
        end
        if (entering) m_alarm = 1;
        else if (a && prev_state == 0) m_alarm = 0;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] t, input logic a);
        rst             = r;
        bus.sampleValid = v;
        bus.temperature = t;
        bus.alarmAck    = a;
        @(posedge clk);
        model_step(r, v, int'(t), a);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 1, 8'd99, 1);
        cycle(1, 0, 8'd0, 0);
        checks += 4;
        if (bus.avgValid !== 1'b0) begin errors++; $display("FAIL reset_avgValid: got %0d expected 0", bus.avgValid); end
        if (bus.avgTemp !== 8'd0) begin errors++; $display("FAIL reset_avgTemp: got %0d expected 0", bus.avgTemp); end
        if (bus.tempState !== 2'b00) begin errors++; $display("FAIL reset_tempState: got %0d expected 0", bus.tempState); end
        if (bus.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %0d expected 0", bus.alarm); end
    endtask

    task automatic test_first_window();
        cycle(0, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'd36, 0);
            checks++;
            if (bus.avgValid !== 1'b0) begin errors++; $display("FAIL fill_no_valid[%0d]: got %0d expected 0", i, bus.avgValid); end
        end
        cycle(0, 1, 8'd36, 0);
        checks += 4;
        if (bus.avgValid !== 1'b1) begin errors++; $display("FAIL first_avgValid: got %0d expected 1", bus.avgValid); end
        if (bus.avgTemp !== 8'd36) begin errors++; $display("FAIL first_avgTemp: got %0d expected 36", bus.avgTemp); end
        if (bus.tempState !== 2'b00) begin errors++; $display("FAIL first_tempState: got %0d expected 0", bus.tempState); end
        if (bus.alarm !== 1'b0) begin errors++; $display("FAIL first_alarm: got %0d expected 0", bus.alarm); end
        cycle(0, 0, 8'd0, 0);
        checks++;
        if (bus.avgValid !== 1'b0) begin errors++; $display("FAIL avgValid_pulse_width: got %0d expected 0", bus.avgValid); end
    endtask

    task automatic test_high_entry();
        int exp_avg[4]   = '{37, 38, 39, 40};
        int exp_state[4] = '{0, 0, 0, 1};
        int exp_alarm[4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 8'd40, 0);
            checks += 4;
            if (bus.avgValid !== 1'b1) begin errors++; $display("FAIL high_valid[%0d]: got %0d expected 1", i, bus.avgValid); end
            if (bus.avgTemp !== 8'(exp_avg[i])) begin errors++; $display("FAIL high_avg[%0d]: got %0d expected %0d", i, bus.avgTemp, exp_avg[i]); end
            if (bus.tempState !== 2'(exp_state[i])) begin errors++; $display("FAIL high_state[%0d]: got %0d expected %0d", i, bus.tempState, exp_state[i]); end
            if (bus.alarm !== 1'(exp_alarm[i])) begin errors++; $display("FAIL high_alarm[%0d]: got %0d expected %0d", i, bus.alarm, exp_alarm[i]); end
        end
    endtask

    task automatic test_high_exit();
        int exp_avg[4] = '{39, 38, 37, 37};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 8'd37, 0);
            checks += 2;
            if (bus.avgTemp !== 8'(exp_avg[i])) begin errors++; $display("FAIL hyst_avg[%0d]: got %0d expected %0d", i, bus.avgTemp, exp_avg[i]); end
            if (bus.tempState !== 2'b01) begin errors++; $display("FAIL hyst_state[%0d]: got %0d expected 1", i, bus.tempState); end
        end
        cycle(0, 1, 8'd36, 0);
        checks += 3;
        if (bus.avgTemp !== 8'd36) begin errors++; $display("FAIL exit_avg: got %0d expected 36", bus.avgTemp); end
        if (bus.tempState !== 2'b00) begin errors++; $display("FAIL exit_state: got %0d expected 0", bus.tempState); end
        if (bus.alarm !== 1'b1) begin errors++; $display("FAIL exit_alarm_sticky: got %0d expected 1", bus.alarm); end
    endtask

    task automatic test_ack();
        cycle(0, 0, 8'd0, 1);
        checks++;
        if (bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_normal_clears: got %0d expected 0", bus.alarm); end
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'd40, 0);
        cycle(0, 1, 8'd40, 1);
        checks += 2;
        if (bus.tempState !== 2'b01) begin errors++; $display("FAIL ack_entry_state: got %0d expected 1", bus.tempState); end
        if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_entry_set_wins: got %0d expected 1", bus.alarm); end
        cycle(0, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 1);
        checks++;
        if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_during_high: got %0d expected 1", bus.alarm); end
    endtask

    task automatic test_low();
        cycle(1, 0, 8'd0, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 1, 8'd34, 0);
            checks += 3;
            if (bus.avgValid !== 1'(i >= 4)) begin errors++; $display("FAIL low_valid[%0d]: got %0d expected %0d", i, bus.avgValid, i >= 4); end
            if (bus.tempState !== ((i == 6) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL low_state[%0d]: got %0d expected %0d", i, bus.tempState, (i == 6) ? 2 : 0); end
            if (bus.alarm !== 1'(i == 6)) begin errors++; $display("FAIL low_alarm[%0d]: got %0d expected %0d", i, bus.alarm, i == 6); end
            if (i >= 4) begin
                checks++;
                if (bus.avgTemp !== 8'd34) begin errors++; $display("FAIL low_avg[%0d]: got %0d expected 34", i, bus.avgTemp); end
            end
        end
        cycle(0, 1, 8'd46, 0);
        checks += 2;
        if (bus.avgTemp !== 8'd37) begin errors++; $display("FAIL low_exit_avg: got %0d expected 37", bus.avgTemp); end
        if (bus.tempState !== 2'b00) begin errors++; $display("FAIL low_exit_state: got %0d expected 0", bus.tempState); end
    endtask

    task automatic test_reset_mid_window();
        cycle(0, 1, 8'd200, 0);
        cycle(0, 1, 8'd200, 0);
        cycle(1, 1, 8'd200, 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, 8'd255, 0);
            checks++;
            if (bus.avgValid !== 1'(i == 4)) begin errors++; $display("FAIL midreset_valid[%0d]: got %0d expected %0d", i, bus.avgValid, i == 4); end
        end
        checks++;
        if (bus.avgTemp !== 8'd255) begin errors++; $display("FAIL midreset_avg_nowrap: got %0d expected 255", bus.avgTemp); end
    endtask

    task automatic test_random();
        logic       r, v, a;
        logic [7:0] t;
        cycle(1, 0, 8'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(30, 44));
            cycle(r, v, t, a);
            checks += 4;
            if (bus.avgValid !== 1'(m_avgvalid)) begin errors++; $display("FAIL rand_avgValid@%0d: got %0d expected %0d", i, bus.avgValid, m_avgvalid); end
            if (bus.avgTemp !== 8'(m_avg)) begin errors++; $display("FAIL rand_avgTemp@%0d: got %0d expected %0d", i, bus.avgTemp, m_avg); end
            if (bus.tempState !== 2'(m_state)) begin errors++; $display("FAIL rand_tempState@%0d: got %0d expected %0d", i, bus.tempState, m_state); end
            if (bus.alarm !== 1'(m_alarm)) begin errors++; $display("FAIL rand_alarm@%0d: got %0d expected %0d", i, bus.alarm, m_alarm); end
        end
    endtask

    initial begin
        bus.sampleValid = 1'b0;
        bus.temperature = 8'd0;
        bus.alarmAck    = 1'b0;
        test_reset();
        test_first_window();
        test_high_entry();
        test_high_exit();
        test_ack();
        test_low();
        test_reset_mid_window();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
